// File: rtl/ravenoc_axi_wr_arb.sv
// ravenoc_axi_wr_arb: round-robin arbiter sharing one AXI4 write path, one grant per full AW/W/B transaction
module ravenoc_axi_wr_arb #(
    parameter int NUM_REQ = 4,
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 64,
    parameter int LEN_W   = 8
) (
    input  logic                      clk_axi,
    input  logic                      rst_axi_n,
    input  logic [NUM_REQ-1:0]        req_awvalid,
    input  logic [NUM_REQ*ADDR_W-1:0] req_awaddr,
    input  logic [NUM_REQ*LEN_W-1:0]  req_awlen,
    output logic [NUM_REQ-1:0]        req_awready,
    input  logic [NUM_REQ-1:0]        req_wvalid,
    input  logic [NUM_REQ*DATA_W-1:0] req_wdata,
    input  logic [NUM_REQ*DATA_W/8-1:0] req_wstrb,
    input  logic [NUM_REQ-1:0]        req_wlast,
    output logic [NUM_REQ-1:0]        req_wready,
    output logic [NUM_REQ-1:0]        req_bvalid,
    output logic [1:0]                req_bresp,
    input  logic [NUM_REQ-1:0]        req_bready,
    output logic                      m_awvalid,
    output logic [ADDR_W-1:0]         m_awaddr,
    output logic [LEN_W-1:0]          m_awlen,
    input  logic                      m_awready,
    output logic                      m_wvalid,
    output logic [DATA_W-1:0]         m_wdata,
    output logic [DATA_W/8-1:0]       m_wstrb,
    output logic                      m_wlast,
    input  logic                      m_wready,
    input  logic                      m_bvalid,
    input  logic [1:0]                m_bresp,
    output logic                      m_bready,
    output logic [NUM_REQ-1:0]        grant_o,
    output logic                      len_err_o
);
    localparam int IW = $clog2(NUM_REQ);
    localparam int SW = DATA_W/8;

    typedef enum logic [1:0] {IDLE, ADDR, DATA, RESP} state_t;

    state_t           state;
    logic [IW-1:0]    sel, rr_ptr, win;
    logic [LEN_W-1:0] awlen_q, beat_cnt;
    logic             in_addr, in_data, in_resp, aw_hs, w_hs, b_hs;

    // Scan downward so the lowest offset from rr_ptr is assigned last and wins.
    always_comb begin
        win = '0;
        for (int k = NUM_REQ-1; k >= 0; k--)
            if (req_awvalid[(int'(rr_ptr)+k) % NUM_REQ])
                win = IW'((int'(rr_ptr)+k) % NUM_REQ);
    end

    always_comb begin
        in_addr     = state == ADDR;
        in_data     = state == DATA;
        in_resp     = state == RESP;
        m_awvalid   = in_addr & req_awvalid[sel];
        m_awaddr    = in_addr ? req_awaddr[int'(sel)*ADDR_W +: ADDR_W] : '0;
        m_awlen     = in_addr ? req_awlen[int'(sel)*LEN_W +: LEN_W] : '0;
        req_awready = (in_addr & m_awready) ? grant_o : '0;
        m_wvalid    = in_data & req_wvalid[sel];
        m_wdata     = in_data ? req_wdata[int'(sel)*DATA_W +: DATA_W] : '0;
        m_wstrb     = in_data ? req_wstrb[int'(sel)*SW +: SW] : '0;
        m_wlast     = in_data & req_wlast[sel];
        req_wready  = (in_data & m_wready) ? grant_o : '0;
        req_bvalid  = (in_resp & m_bvalid) ? grant_o : '0;
        req_bresp   = in_resp ? m_bresp : '0;
        m_bready    = in_resp & req_bready[sel];
        aw_hs       = m_awvalid & m_awready;
        w_hs        = m_wvalid & m_wready;
        b_hs        = m_bvalid & m_bready;
    end

    always_ff @(posedge clk_axi) begin
        if (!rst_axi_n) begin
            state     <= IDLE;
            sel       <= '0;
            rr_ptr    <= '0;
            grant_o   <= '0;
            awlen_q   <= '0;
            beat_cnt  <= '0;
            len_err_o <= 1'b0;
        end else begin
            len_err_o <= 1'b0;
            unique case (state)
                IDLE: if (|req_awvalid) begin
                    sel     <= win;
                    grant_o <= NUM_REQ'(1) << win;
                    state   <= ADDR;
                end
                ADDR: if (aw_hs) begin
                    awlen_q  <= m_awlen;
                    beat_cnt <= '0;
                    state    <= DATA;
                end
                DATA: if (w_hs) begin
                    beat_cnt  <= beat_cnt + 1'b1;
                    len_err_o <= m_wlast ? beat_cnt != awlen_q : beat_cnt == awlen_q;
                    if (m_wlast)
                        state <= RESP;
                end
                RESP: if (b_hs) begin
                    rr_ptr  <= sel == IW'(NUM_REQ-1) ? '0 : sel + 1'b1;
                    grant_o <= '0;
                    state   <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_ravenoc_axi_wr_arb.sv
// tb_ravenoc_axi_wr_arb: directed checks of grant order, routing, length errors and reset
module tb_ravenoc_axi_wr_arb;
    logic         clk_axi = 1'b0;
    logic         rst_axi_n = 1'b0;
    logic [3:0]   req_awvalid = '0;
    logic [127:0] req_awaddr = '0;
    logic [31:0]  req_awlen = '0;
    logic [3:0]   req_awready;
    logic [3:0]   req_wvalid = '0;
    logic [255:0] req_wdata = '0;
    logic [31:0]  req_wstrb = '0;
    logic [3:0]   req_wlast = '0;
    logic [3:0]   req_wready;
    logic [3:0]   req_bvalid;
    logic [1:0]   req_bresp;
    logic [3:0]   req_bready = '0;
    logic         m_awvalid;
    logic [31:0]  m_awaddr;
    logic [7:0]   m_awlen;
    logic         m_awready = 1'b1;
    logic         m_wvalid;
    logic [63:0]  m_wdata;
    logic [7:0]   m_wstrb;
    logic         m_wlast;
    logic         m_wready = 1'b0;
    logic         m_bvalid = 1'b0;
    logic [1:0]   m_bresp = '0;
    logic         m_bready;
    logic [3:0]   grant_o;
    logic         len_err_o;

    int n_checks = 0, n_errors = 0, n_beats = 0, n_lerr = 0, wc;
    int b0, l0, q0;
    logic ph = 1'b1;
    logic [63:0] wq[$];

    ravenoc_axi_wr_arb dut (
        .clk_axi(clk_axi), .rst_axi_n(rst_axi_n),
        .req_awvalid(req_awvalid), .req_awaddr(req_awaddr), .req_awlen(req_awlen),
        .req_awready(req_awready), .req_wvalid(req_wvalid), .req_wdata(req_wdata),
        .req_wstrb(req_wstrb), .req_wlast(req_wlast), .req_wready(req_wready),
        .req_bvalid(req_bvalid), .req_bresp(req_bresp), .req_bready(req_bready),
        .m_awvalid(m_awvalid), .m_awaddr(m_awaddr), .m_awlen(m_awlen), .m_awready(m_awready),
        .m_wvalid(m_wvalid), .m_wdata(m_wdata), .m_wstrb(m_wstrb), .m_wlast(m_wlast),
        .m_wready(m_wready), .m_bvalid(m_bvalid), .m_bresp(m_bresp), .m_bready(m_bready),
        .grant_o(grant_o), .len_err_o(len_err_o)
    );

    always #5 clk_axi = ~clk_axi;

    always @(negedge clk_axi) begin
        if (len_err_o) n_lerr++;
        if (m_wvalid && m_wready) begin
            n_beats++;
            wq.push_back(m_wdata);
        end
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk_axi);
        #1;
    endtask

    task automatic do_reset;
        rst_axi_n = 1'b0;
        tick();
        tick();
        check("rst_grant", 64'(grant_o), 0);
        check("rst_outs", 64'({m_awvalid, m_wvalid, m_bready, len_err_o}), 0);
        rst_axi_n = 1'b1;
    endtask

    task automatic req_aw(input int r, input logic [7:0] len);
        req_awvalid[r] = 1'b1;
        req_awaddr[r*32 +: 32] = 32'hA000 + 32'(r);
        req_awlen[r*8 +: 8] = len;
    endtask

    task automatic wait_grant(input int r);
        for (wc = 1; wc <= 20; wc++) begin
            tick();
            if (grant_o != 0) break;
        end
        check($sformatf("grant_r%0d", r), 64'(grant_o), 64'(4'b1 << r));
    endtask

    // Full transaction for requester r, which must already be requesting.
    task automatic txn(input int r, input int nbeats, input bit bp, input logic [63:0] base, input logic [1:0] resp);
        logic hs;
        wait_grant(r);
        check("awvalid", 64'(m_awvalid), 1);
        check("awaddr", 64'(m_awaddr), 64'h A000 + 64'(r));
        check("awready", 64'(req_awready), 64'(4'b1 << r));
        tick();
        req_awvalid[r] = 1'b0;
        for (int b = 0; b < nbeats; b++) begin
            req_wvalid[r] = 1'b1;
            req_wdata[r*64 +: 64] = base + 64'(b);
            req_wstrb[r*8 +: 8] = 8'hF0 | 8'(b);
            req_wlast[r] = b == nbeats-1;
            do begin
                hs = bp ? ph : 1'b1;
                m_wready = hs;
                ph = ~ph;
                #1;
                if (hs) begin
                    check("wready", 64'(req_wready), 64'(4'b1 << r));
                    check("wstrb", 64'(m_wstrb), 64'(8'hF0 | 8'(b)));
                end
                tick();
            end while (!hs);
        end
        req_wvalid[r] = 1'b0;
        req_wlast[r] = 1'b0;
        m_wready = 1'b0;
        req_bready[r] = 1'b1;
        m_bvalid = 1'b1;
        m_bresp = resp;
        #1;
        check("bvalid", 64'(req_bvalid), 64'(4'b1 << r));
        check("bready", 64'(m_bready), 1);
        check("bresp", 64'(req_bresp), 64'(resp));
        tick();
        m_bvalid = 1'b0;
        req_bready[r] = 1'b0;
        check("grant_rel", 64'(grant_o), 0);
    endtask

    initial begin
        do_reset();

        // single requester, AWLEN=3
        b0 = n_beats; q0 = wq.size(); l0 = n_lerr;
        req_aw(2, 8'd3);
        wait_grant(2);
        check("t1_latency", 64'(wc), 1);
        check("t1_awlen", 64'(m_awlen), 3);
        tick();
        req_awvalid[2] = 1'b0;
        for (int b = 0; b < 4; b++) begin
            req_wvalid[2] = 1'b1;
            req_wdata[128 +: 64] = 64'h2200 + 64'(b);
            req_wlast[2] = b == 3;
            m_wready = 1'b1;
            tick();
        end
        req_wvalid[2] = 1'b0;
        req_wlast[2] = 1'b0;
        m_wready = 1'b0;
        m_bvalid = 1'b1;
        m_bresp = 2'b00;
        req_bready = 4'b1111;
        #1;
        check("t1_bvalid", 64'(req_bvalid), 64'(4'b0100));
        check("t1_bready", 64'(m_bready), 1);
        tick();
        m_bvalid = 1'b0;
        req_bready = '0;
        check("t1_beats", 64'(n_beats - b0), 4);
        for (int i = 0; i < 4; i++) check("t1_data", wq[q0+i], 64'h2200 + 64'(i));
        check("t1_lerr", 64'(n_lerr - l0), 0);

        // all four together from reset, then 0 and 3 together after 3 was served
        do_reset();
        l0 = n_lerr;
        for (int r = 0; r < 4; r++) req_aw(r, 8'd0);
        for (int r = 0; r < 4; r++) txn(r, 1, 1'b0, 64'h100 * 64'(r), 2'b00);
        check("t2_lerr", 64'(n_lerr - l0), 0);
        req_aw(3, 8'd0);
        req_aw(0, 8'd0);
        txn(0, 1, 1'b0, 64'h500, 2'b01);
        txn(3, 1, 1'b0, 64'h600, 2'b00);

        // backpressure, AWLEN=7
        b0 = n_beats; q0 = wq.size(); l0 = n_lerr; ph = 1'b1;
        req_aw(1, 8'd7);
        txn(1, 8, 1'b1, 64'hBEEF_0000, 2'b00);
        check("t4_beats", 64'(n_beats - b0), 8);
        for (int i = 0; i < 8; i++) check("t4_data", wq[q0+i], 64'hBEEF_0000 + 64'(i));
        check("t4_lerr", 64'(n_lerr - l0), 0);

        // early wlast: AWLEN=3, wlast on beat 2; txn itself checks that B is routed
        l0 = n_lerr;
        req_aw(0, 8'd3);
        txn(0, 3, 1'b0, 64'h700, 2'b10);
        check("t5_lerr", 64'(n_lerr - l0), 1);

        // reset in DATA after beat 1
        req_aw(2, 8'd3);
        wait_grant(2);
        tick();
        req_awvalid[2] = 1'b0;
        req_wvalid[2] = 1'b1;
        req_wdata[128 +: 64] = 64'h1234;
        m_wready = 1'b1;
        tick();
        tick();
        rst_axi_n = 1'b0;
        m_bvalid = 1'b1;
        m_bresp = 2'b10;
        req_bready = 4'b1111;
        tick();
        check("t6_grant", 64'(grant_o), 0);
        check("t6_wpath", 64'({m_wvalid, req_wready, m_awvalid, req_awready, m_wlast}), 0);
        check("t6_bpath", 64'({req_bvalid, m_bready, req_bresp, len_err_o}), 0);
        check("t6_wdata", m_wdata, 0);
        rst_axi_n = 1'b1;
        req_wvalid = '0;
        m_wready = 1'b0;
        m_bvalid = 1'b0;
        req_bready = '0;
        tick();
        req_aw(2, 8'd0);
        req_aw(0, 8'd0);
        txn(0, 1, 1'b0, 64'h800, 2'b00);
        txn(2, 1, 1'b0, 64'h900, 2'b00);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
